// File: rtl/i2c_ctrl_pkg.sv
// i2c_ctrl_pkg
//   Shared types and constants for the I2C transaction scheduler:
//   the scheduler state enum, the 2-bit completion status codes and
//   the engine rd_wr direction encoding.
package i2c_ctrl_pkg;

  // One complete transaction walks IDLE -> START -> ADDR -> DATA -> STOP.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_ADDR  = 3'd2,
    S_DATA  = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  // Completion status reported alongside the done pulse.
  localparam logic [1:0] ST_OK        = 2'b00;
  localparam logic [1:0] ST_ADDR_NACK = 2'b01;
  localparam logic [1:0] ST_DATA_NACK = 2'b10;
  localparam logic [1:0] ST_TIMEOUT   = 2'b11;

  // Engine rd_wr encoding.
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/i2c_rr_arbiter.sv
// i2c_rr_arbiter
//   Round-robin arbiter over NREQ requesters. The search for a winner
//   starts one position after the most recent winner and wraps, so a
//   requester that just got served has the lowest priority next time.
//
// Ports:
//   clk      system clock
//   reset    synchronous active-high reset (pointer returns to 0)
//   req      request vector
//   take     winner accepted this cycle; pointer moves to the winner
//   gnt      one-hot winner (combinational, zero when req is zero)
//   gnt_idx  binary index of the winner
module i2c_rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req,
  input  logic                      take,
  output logic [NREQ-1:0]           gnt,
  output logic [$clog2(NREQ)-1:0]   gnt_idx
);

  localparam int IW = $clog2(NREQ);

  logic [IW-1:0] ptr_q;
  logic          found;
  int            cand;

  // Scan ptr+1, ptr+2, ... ptr+NREQ (mod NREQ); the first hit wins.
  // The last candidate is ptr itself, so a lone requester always wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = 0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = (int'(ptr_q) + i) % NREQ;
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = IW'(cand);
      end
    end
  end

  // Pointer remembers the last accepted winner.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (take) begin
      ptr_q <= gnt_idx;
    end
  end

endmodule

// File: rtl/i2c_txn_scheduler.sv
// i2c_txn_scheduler
//   Arbitrates NREQ requesters onto a single-byte I2C master engine and
//   sequences one full transaction at a time: START, address byte,
//   req_len data bytes, STOP. A watchdog aborts the transaction with a
//   timeout status if the engine goes quiet for TIMEOUT cycles.
//
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   req          per-requester level request
//   req_addr     7-bit slave address per requester (packed, 7*NREQ)
//   req_rw       per-requester direction (1 read, 0 write)
//   req_len      per-requester data byte count (0 = address-only probe)
//   req_wdata    per-requester first-word-fall-through write byte
//   grant        one-hot owner, held for the whole transaction
//   tx_pop       one-hot pulse: owner's write byte consumed
//   rx_data      read byte, qualified by rx_valid
//   rx_valid     one-hot pulse for rx_data
//   done         one-hot pulse at transaction end
//   status       completion code, valid with done
//   m_start      engine start pulse
//   m_stop       engine stop request
//   m_rd_wr      engine direction
//   m_address    engine slave address
//   m_din        engine write byte
//   m_byte_done  engine finished a byte and its ack slot
//   m_ack        slave ack, sampled with m_byte_done
//   m_dout       engine read byte, valid with m_byte_done
//   m_idle       engine idle, bus released
module i2c_txn_scheduler
  import i2c_ctrl_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [7*NREQ-1:0]     req_addr,
  input  logic [NREQ-1:0]       req_rw,
  input  logic [LEN_W*NREQ-1:0] req_len,
  input  logic [8*NREQ-1:0]     req_wdata,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       tx_pop,
  output logic [7:0]            rx_data,
  output logic [NREQ-1:0]       rx_valid,
  output logic [NREQ-1:0]       done,
  output logic [1:0]            status,
  output logic                  m_start,
  output logic                  m_stop,
  output logic                  m_rd_wr,
  output logic [6:0]            m_address,
  output logic [7:0]            m_din,
  input  logic                  m_byte_done,
  input  logic                  m_ack,
  input  logic [7:0]            m_dout,
  input  logic                  m_idle
);

  localparam int IW = $clog2(NREQ);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t            state_q, state_d;
  logic [NREQ-1:0]   grant_q;
  logic [IW-1:0]     gidx_q;
  logic [6:0]        addr_q;
  logic              rw_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [1:0]        code_q, code_d;
  logic [TW-1:0]     timer_q;
  logic [7:0]        din_q;
  logic [7:0]        rx_data_q;
  logic [NREQ-1:0]   rx_valid_q;
  logic [NREQ-1:0]   done_q;
  logic [1:0]        status_q;

  logic              arb_take;
  logic [NREQ-1:0]   arb_gnt;
  logic [IW-1:0]     arb_idx;
  logic              load_din;
  logic              rx_fire;
  logic              finish;
  logic              expire;
  logic              start_c;
  logic              stop_c;

  // A new transaction is only accepted while the engine has released the bus.
  assign arb_take = (state_q == S_IDLE) && m_idle && (|req);

  i2c_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .take    (arb_take),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  // Next-state and per-cycle strobes. A byte_done landing in the same
  // cycle the watchdog would fire wins over the timeout.
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    code_d   = code_q;
    load_din = 1'b0;
    rx_fire  = 1'b0;
    finish   = 1'b0;
    start_c  = 1'b0;
    stop_c   = 1'b0;
    expire   = (timer_q == TW'(TIMEOUT - 1)) && !m_byte_done;

    case (state_q)
      S_IDLE: begin
        if (arb_take) begin
          state_d = S_START;
          code_d  = ST_OK;
        end
      end

      S_START: begin
        start_c = 1'b1;
        // Prefetch the first write byte so it is on m_din before the
        // address byte completes.
        if (rw_q == RW_WRITE && len_q != '0) begin
          load_din = 1'b1;
        end
        state_d = S_ADDR;
      end

      S_ADDR: begin
        stop_c = (len_q == '0);
        if (m_byte_done) begin
          if (!m_ack) begin
            code_d  = ST_ADDR_NACK;
            state_d = S_STOP;
          end else if (len_q == '0) begin
            state_d = S_STOP;
          end else begin
            rem_d   = len_q;
            state_d = S_DATA;
          end
        end else if (expire) begin
          code_d  = ST_TIMEOUT;
          finish  = 1'b1;
          state_d = S_IDLE;
        end
      end

      S_DATA: begin
        // Raised during the last byte so the engine stops after its ack slot.
        stop_c = (rem_q == LEN_W'(1));
        if (m_byte_done) begin
          if (rw_q == RW_WRITE && !m_ack) begin
            code_d  = ST_DATA_NACK;
            state_d = S_STOP;
          end else begin
            if (rem_q != '0) begin
              rem_d = rem_q - LEN_W'(1);
            end
            if (rw_q == RW_READ) begin
              rx_fire = 1'b1;
            end else if (rem_q > LEN_W'(1)) begin
              load_din = 1'b1;
            end
            if (rem_q <= LEN_W'(1)) begin
              state_d = S_STOP;
            end
          end
        end else if (expire) begin
          code_d  = ST_TIMEOUT;
          finish  = 1'b1;
          state_d = S_IDLE;
        end
      end

      S_STOP: begin
        stop_c = 1'b1;
        if (m_idle) begin
          finish  = 1'b1;
          state_d = S_IDLE;
        end else if (expire) begin
          code_d  = ST_TIMEOUT;
          finish  = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Watchdog: restarts on every state change and every engine byte event.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q <= '0;
    end else if (state_d != state_q || m_byte_done) begin
      timer_q <= '0;
    end else if (state_q == S_ADDR || state_q == S_DATA || state_q == S_STOP) begin
      timer_q <= timer_q + TW'(1);
    end
  end

  // Transaction context latched at grant time; requester changes during
  // the transaction are deliberately ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_q <= '0;
      gidx_q  <= '0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      len_q   <= '0;
      rem_q   <= '0;
      code_q  <= ST_OK;
    end else begin
      rem_q  <= rem_d;
      code_q <= code_d;
      if (arb_take) begin
        grant_q <= arb_gnt;
        gidx_q  <= arb_idx;
        addr_q  <= req_addr[int'(arb_idx)*7 +: 7];
        rw_q    <= req_rw[arb_idx];
        len_q   <= req_len[int'(arb_idx)*LEN_W +: LEN_W];
      end else if (finish) begin
        grant_q <= '0;
      end
    end
  end

  // Registered data path toward the engine and back to the requesters.
  always_ff @(posedge clk) begin
    if (reset) begin
      din_q      <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= '0;
      done_q     <= '0;
      status_q   <= ST_OK;
    end else begin
      if (load_din) begin
        din_q <= req_wdata[int'(gidx_q)*8 +: 8];
      end
      if (rx_fire) begin
        rx_data_q <= m_dout;
      end
      rx_valid_q <= rx_fire ? grant_q : '0;
      done_q     <= finish ? grant_q : '0;
      if (finish) begin
        status_q <= code_d;
      end
    end
  end

  assign grant     = grant_q;
  assign tx_pop    = load_din ? grant_q : '0;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign done      = done_q;
  assign status    = status_q;
  assign m_start   = start_c;
  assign m_stop    = stop_c;
  assign m_rd_wr   = rw_q;
  assign m_address = addr_q;
  assign m_din     = din_q;

endmodule

// File: tb/tb_i2c_txn_scheduler.sv
// tb_i2c_txn_scheduler
//   Directed bench for i2c_txn_scheduler (NREQ=4, LEN_W=4, TIMEOUT=16).
//   The engine side is driven by hand, one byte event at a time; each
//   requester's write bytes come from a small FWFT model that advances
//   on tx_pop.
module tb_i2c_txn_scheduler;

  localparam int NREQ    = 4;
  localparam int LEN_W   = 4;
  localparam int TIMEOUT = 16;

  logic                  clk;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [7*NREQ-1:0]     req_addr;
  logic [NREQ-1:0]       req_rw;
  logic [LEN_W*NREQ-1:0] req_len;
  logic [8*NREQ-1:0]     req_wdata;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       tx_pop;
  logic [7:0]            rx_data;
  logic [NREQ-1:0]       rx_valid;
  logic [NREQ-1:0]       done;
  logic [1:0]            status;
  logic                  m_start;
  logic                  m_stop;
  logic                  m_rd_wr;
  logic [6:0]            m_address;
  logic [7:0]            m_din;
  logic                  m_byte_done;
  logic                  m_ack;
  logic [7:0]            m_dout;
  logic                  m_idle;

  int check_count = 0;
  int pass_count  = 0;

  logic [7:0] wbytes [NREQ][16];
  logic [3:0] wptr   [NREQ] = '{default: 4'd0};
  int         pop_cnt[NREQ] = '{default: 0};

  i2c_txn_scheduler #(
    .NREQ(NREQ), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_addr    (req_addr),
    .req_rw      (req_rw),
    .req_len     (req_len),
    .req_wdata   (req_wdata),
    .grant       (grant),
    .tx_pop      (tx_pop),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .done        (done),
    .status      (status),
    .m_start     (m_start),
    .m_stop      (m_stop),
    .m_rd_wr     (m_rd_wr),
    .m_address   (m_address),
    .m_din       (m_din),
    .m_byte_done (m_byte_done),
    .m_ack       (m_ack),
    .m_dout      (m_dout),
    .m_idle      (m_idle)
  );

  // 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Requester write FIFOs: the head byte is always presented, and a
  // tx_pop moves to the next one.
  always_comb begin
    req_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_wdata[i*8 +: 8] = wbytes[i][wptr[i]];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (tx_pop[i]) begin
        wptr[i]    <= wptr[i] + 4'd1;
        pop_cnt[i] <= pop_cnt[i] + 1;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      pass_count++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int idx, input logic [6:0] addr, input logic rw,
                               input logic [3:0] len);
    req_addr[idx*7 +: 7]         = addr;
    req_rw[idx]                  = rw;
    req_len[idx*LEN_W +: LEN_W]  = len;
    req[idx]                     = 1'b1;
  endtask

  task automatic byteDone(input logic ack, input logic [7:0] dout);
    m_byte_done = 1'b1;
    m_ack       = ack;
    m_dout      = dout;
    tick();
    m_byte_done = 1'b0;
    m_ack       = 1'b0;
  endtask

  initial begin
    logic [NREQ-1:0] rr_order [5];
    rr_order[0] = 4'b0001;
    rr_order[1] = 4'b0010;
    rr_order[2] = 4'b0100;
    rr_order[3] = 4'b1000;
    rr_order[4] = 4'b0001;

    for (int i = 0; i < NREQ; i++) begin
      for (int j = 0; j < 16; j++) wbytes[i][j] = 8'h00;
    end
    wbytes[0][0] = 8'hA1; wbytes[0][1] = 8'hB2; wbytes[0][2] = 8'hC3;
    wbytes[3][0] = 8'h31; wbytes[3][1] = 8'h32;
    wbytes[2][0] = 8'h71; wbytes[2][1] = 8'h72; wbytes[2][2] = 8'h73;

    reset = 1'b1; req = '0; req_addr = '0; req_rw = '0; req_len = '0;
    m_byte_done = 1'b0; m_ack = 1'b0; m_dout = 8'h00; m_idle = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    $display("[TB] reset state");
    checkOutput("rst_grant", 32'(grant), 32'h0);
    checkOutput("rst_done", 32'(done), 32'h0);
    checkOutput("rst_mstart", 32'(m_start), 32'h0);
    checkOutput("rst_mstop", 32'(m_stop), 32'h0);
    checkOutput("rst_maddr", 32'(m_address), 32'h0);

    // ---- req0 write 0x50, three bytes, all acked
    $display("[TB] req0 write len 3");
    applyStimulus(0, 7'h50, 1'b0, 4'd3);
    tick();
    checkOutput("w_grant", 32'(grant), 32'h1);
    checkOutput("w_start", 32'(m_start), 32'h1);
    checkOutput("w_addr", 32'(m_address), 32'h50);
    checkOutput("w_rdwr", 32'(m_rd_wr), 32'h0);
    checkOutput("w_pop_start", 32'(tx_pop), 32'h1);
    req = '0; m_idle = 1'b0;
    tick();
    checkOutput("w_start_pulse", 32'(m_start), 32'h0);
    checkOutput("w_din0", 32'(m_din), 32'hA1);
    byteDone(1'b1, 8'h00);
    checkOutput("w_din0_hold", 32'(m_din), 32'hA1);
    checkOutput("w_stop_b1", 32'(m_stop), 32'h0);
    byteDone(1'b1, 8'h00);
    checkOutput("w_din1", 32'(m_din), 32'hB2);
    checkOutput("w_stop_b2", 32'(m_stop), 32'h0);
    byteDone(1'b1, 8'h00);
    checkOutput("w_din2", 32'(m_din), 32'hC3);
    checkOutput("w_stop_b3", 32'(m_stop), 32'h1);
    byteDone(1'b1, 8'h00);
    checkOutput("w_pops", 32'(pop_cnt[0]), 32'd3);
    checkOutput("w_stop_hold", 32'(m_stop), 32'h1);
    checkOutput("w_nodone", 32'(done), 32'h0);
    m_idle = 1'b1;
    tick();
    checkOutput("w_done", 32'(done), 32'h1);
    checkOutput("w_status", 32'(status), 32'h0);
    checkOutput("w_grant_clr", 32'(grant), 32'h0);
    tick();
    checkOutput("w_done_pulse", 32'(done), 32'h0);

    // ---- req2 read 0x3C, two bytes
    $display("[TB] req2 read len 2");
    applyStimulus(2, 7'h3C, 1'b1, 4'd2);
    tick();
    checkOutput("r_grant", 32'(grant), 32'h4);
    checkOutput("r_addr", 32'(m_address), 32'h3C);
    checkOutput("r_rdwr", 32'(m_rd_wr), 32'h1);
    checkOutput("r_nopop", 32'(tx_pop), 32'h0);
    req = '0; m_idle = 1'b0;
    tick();
    byteDone(1'b1, 8'h00);
    byteDone(1'b1, 8'h5A);
    checkOutput("r_valid0", 32'(rx_valid), 32'h4);
    checkOutput("r_data0", 32'(rx_data), 32'h5A);
    checkOutput("r_stop_last", 32'(m_stop), 32'h1);
    tick();
    checkOutput("r_valid_gap", 32'(rx_valid), 32'h0);
    byteDone(1'b1, 8'hA5);
    checkOutput("r_valid1", 32'(rx_valid), 32'h4);
    checkOutput("r_data1", 32'(rx_data), 32'hA5);
    m_idle = 1'b1;
    tick();
    checkOutput("r_done", 32'(done), 32'h4);
    checkOutput("r_status", 32'(status), 32'h0);

    // ---- req3 write len 4, address NACK
    $display("[TB] req3 address nack");
    applyStimulus(3, 7'h21, 1'b0, 4'd4);
    tick();
    checkOutput("n_grant", 32'(grant), 32'h8);
    req = '0; m_idle = 1'b0;
    tick();
    byteDone(1'b0, 8'h00);
    repeat (3) tick();
    checkOutput("n_done_wait", 32'(done), 32'h0);
    checkOutput("n_stop", 32'(m_stop), 32'h1);
    checkOutput("n_pops", 32'(pop_cnt[3]), 32'd1);
    m_idle = 1'b1;
    tick();
    checkOutput("n_done", 32'(done), 32'h8);
    checkOutput("n_status", 32'(status), 32'h1);

    // ---- all four requesting address-only probes: round robin
    $display("[TB] round robin probes");
    for (int i = 0; i < NREQ; i++) applyStimulus(i, 7'(8'h10 + i), 1'b0, 4'd0);
    for (int k = 0; k < 5; k++) begin
      m_idle = 1'b1;
      tick();
      checkOutput($sformatf("rr_grant%0d", k), 32'(grant), 32'(rr_order[k]));
      m_idle = 1'b0;
      tick();
      checkOutput($sformatf("rr_stop%0d", k), 32'(m_stop), 32'h1);
      byteDone(1'b1, 8'h00);
      m_idle = 1'b1;
      tick();
      checkOutput($sformatf("rr_done%0d", k), 32'(done), 32'(rr_order[k]));
      checkOutput($sformatf("rr_status%0d", k), 32'(status), 32'h0);
    end
    req = '0;

    // ---- req1 read, engine goes silent after start
    $display("[TB] watchdog timeout");
    applyStimulus(1, 7'h44, 1'b1, 4'd1);
    tick();
    checkOutput("t_grant", 32'(grant), 32'h2);
    req = '0; m_idle = 1'b0;
    tick();
    repeat (TIMEOUT - 1) tick();
    checkOutput("t_early", 32'(done), 32'h0);
    tick();
    checkOutput("t_done", 32'(done), 32'h2);
    checkOutput("t_status", 32'(status), 32'h3);
    checkOutput("t_grant_clr", 32'(grant), 32'h0);

    // ---- reset in the middle of a five-byte write
    $display("[TB] reset mid transaction");
    m_idle = 1'b1;
    applyStimulus(2, 7'h11, 1'b0, 4'd5);
    tick();
    checkOutput("x_grant", 32'(grant), 32'h4);
    req = '0; m_idle = 1'b0;
    tick();
    byteDone(1'b1, 8'h00);
    byteDone(1'b1, 8'h00);
    reset = 1'b1;
    tick();
    checkOutput("x_grant_rst", 32'(grant), 32'h0);
    checkOutput("x_din_rst", 32'(m_din), 32'h0);
    checkOutput("x_stop_rst", 32'(m_stop), 32'h0);
    checkOutput("x_addr_rst", 32'(m_address), 32'h0);
    checkOutput("x_done_rst", 32'(done), 32'h0);
    reset = 1'b0; m_idle = 1'b1;
    for (int i = 0; i < NREQ; i++) applyStimulus(i, 7'(8'h20 + i), 1'b0, 4'd0);
    tick();
    checkOutput("x_nodone", 32'(done), 32'h0);
    checkOutput("x_ptr0_grant", 32'(grant), 32'h2);
    req = '0;
    tick();

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
